// File: rtl/vote_hub.sv
// Vote hub: collects local votes, swaps with a peer over rts/cts and ctr/rtr, and reports the AND-merged majority.
// Latency: outputs are registered, one cycle after the deciding edge; peer handshakes stall up to TIMEOUT cycles, then ERROR.
module vote_hub #(
    parameter int N_VOTERS = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                key,
    input  logic                test,
    input  logic [N_VOTERS-1:0] vote_btn,
    input  logic                rts,
    input  logic [N_VOTERS-1:0] v_in,
    input  logic                rtr,
    output logic                cts,
    output logic                ctr,
    output logic [N_VOTERS-1:0] v_out,
    output logic                pass,
    output logic                err,
    output logic                busy
);

    localparam int             CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_COLLECT, S_RX_WAIT, S_RX_ACK, S_MERGE,
        S_TX_WAIT, S_TX_ACK, S_TEST, S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic                  start_q;
    logic [N_VOTERS-1:0]   btn_q;
    logic [N_VOTERS-1:0]   local_q, local_d;
    logic [N_VOTERS-1:0]   remote_q, remote_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  cts_q, cts_d;
    logic                  ctr_q, ctr_d;
    logic [N_VOTERS-1:0]   vout_q, vout_d;
    logic                  pass_q, pass_d;
    logic                  err_q, err_d;
    logic                  busy_q;

    logic                  start_rise;
    logic [N_VOTERS-1:0]   btn_rise;
    logic                  in_hs;
    logic                  awaited;
    logic [N_VOTERS-1:0]   merged;
    int                    ones;

    assign start_rise = start & ~start_q;
    assign btn_rise   = vote_btn & ~btn_q;

    always_comb begin
        merged = local_q & remote_q;
        ones   = 0;
        for (int i = 0; i < N_VOTERS; i++) begin
            ones = ones + int'(merged[i]);
        end
    end

    // The four handshake states share one wait/timeout mechanism.
    always_comb begin
        in_hs   = 1'b0;
        awaited = 1'b0;
        case (state_q)
            S_RX_WAIT: begin in_hs = 1'b1; awaited = rts;  end
            S_RX_ACK:  begin in_hs = 1'b1; awaited = ~rts; end
            S_TX_WAIT: begin in_hs = 1'b1; awaited = rtr;  end
            S_TX_ACK:  begin in_hs = 1'b1; awaited = ~rtr; end
            default:   begin in_hs = 1'b0; awaited = 1'b0; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        local_d  = local_q;
        remote_d = remote_q;
        cnt_d    = cnt_q;
        cts_d    = cts_q;
        ctr_d    = ctr_q;
        vout_d   = vout_q;
        pass_d   = pass_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    local_d = '0;
                    state_d = S_COLLECT;
                end else if (test) begin
                    vout_d  = N_VOTERS'(1);
                    state_d = S_TEST;
                end
            end
            S_TEST: begin
                if (!test) begin
                    vout_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    vout_d = {vout_q[N_VOTERS-2:0], vout_q[N_VOTERS-1]};
                end
            end
            S_COLLECT: begin
                local_d = local_q | (btn_rise & {N_VOTERS{key}});
                if (start_rise) state_d = S_RX_WAIT;
            end
            S_RX_WAIT: begin
                if (awaited) begin
                    remote_d = v_in;
                    cts_d    = 1'b1;
                    state_d  = S_RX_ACK;
                end
            end
            S_RX_ACK: begin
                if (awaited) begin
                    cts_d   = 1'b0;
                    state_d = S_MERGE;
                end
            end
            S_MERGE: begin
                vout_d  = merged;
                pass_d  = (2 * ones) > N_VOTERS;
                ctr_d   = 1'b1;
                state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (awaited) begin
                    ctr_d   = 1'b0;
                    state_d = S_TX_ACK;
                end
            end
            S_TX_ACK: begin
                if (awaited) state_d = S_IDLE;
            end
            S_ERROR: begin
                if (start_rise) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A condition arriving in the expiry cycle wins over the timeout.
        if (in_hs && !awaited && cnt_q == TO_VAL) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            cts_d   = 1'b0;
            ctr_d   = 1'b0;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (in_hs) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            btn_q    <= '0;
            local_q  <= '0;
            remote_q <= '0;
            cnt_q    <= '0;
            cts_q    <= 1'b0;
            ctr_q    <= 1'b0;
            vout_q   <= '0;
            pass_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            btn_q    <= vote_btn;
            local_q  <= local_d;
            remote_q <= remote_d;
            cnt_q    <= cnt_d;
            cts_q    <= cts_d;
            ctr_q    <= ctr_d;
            vout_q   <= vout_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            busy_q   <= (state_d != S_IDLE);
        end
    end

    assign cts   = cts_q;
    assign ctr   = ctr_q;
    assign v_out = vout_q;
    assign pass  = pass_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_vote_hub.sv
// Bench for vote_hub: a rule-level reference model compared every negedge, plus directed literal checks.
// Inputs change 2 time units after a rising edge; DUT outputs are sampled away from the rising edge.
module tb_vote_hub;

    localparam int N  = 4;
    localparam int TO = 15;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic         key;
    logic         test;
    logic [N-1:0] vote_btn;
    logic         rts;
    logic [N-1:0] v_in;
    logic         rtr;
    logic         cts;
    logic         ctr;
    logic [N-1:0] v_out;
    logic         pass;
    logic         err;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    vote_hub #(.N_VOTERS(N), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .key(key), .test(test),
        .vote_btn(vote_btn), .rts(rts), .v_in(v_in), .rtr(rtr),
        .cts(cts), .ctr(ctr), .v_out(v_out), .pass(pass), .err(err), .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: phases named after the protocol, wait time as a plain cycle tally.
    localparam int P_IDLE = 0, P_COL = 1, P_RXW = 2, P_RXA = 3, P_MRG = 4,
                   P_TXW = 5, P_TXA = 6, P_TST = 7, P_ERR = 8;

    int           ph = P_IDLE;
    int           waited = 0;
    logic [N-1:0] loc = '0, rem = '0, pbtn = '0, brise = '0;
    logic         pst = 1'b0, srise = 1'b0, met = 1'b0;
    logic         m_cts = 1'b0, m_ctr = 1'b0, m_pass = 1'b0, m_err = 1'b0, m_busy = 1'b0;
    logic [N-1:0] m_vout = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ph = P_IDLE; waited = 0; loc = '0; rem = '0; pbtn = '0; pst = 1'b0;
            m_cts = 1'b0; m_ctr = 1'b0; m_pass = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_vout = '0;
        end else begin
            srise = start && !pst;
            brise = vote_btn & ~pbtn;
            pst   = start;
            pbtn  = vote_btn;
            met   = (ph == P_RXW && rts) || (ph == P_RXA && !rts) ||
                    (ph == P_TXW && rtr) || (ph == P_TXA && !rtr);
            case (ph)
                P_IDLE: if (srise) begin loc = '0; ph = P_COL; end
                        else if (test) begin m_vout = N'(1); ph = P_TST; end
                P_TST:  if (!test) begin m_vout = '0; ph = P_IDLE; end
                        else m_vout = N'((32'(m_vout) << 1) | (32'(m_vout) >> (N - 1)));
                P_COL: begin
                    if (key) loc = loc | brise;
                    if (srise) begin ph = P_RXW; waited = 0; end
                end
                P_MRG: begin
                    m_vout = loc & rem;
                    m_pass = (2 * $countones(m_vout)) > N;
                    m_ctr  = 1'b1;
                    ph = P_TXW; waited = 0;
                end
                P_ERR:  if (srise) begin m_err = 1'b0; ph = P_IDLE; end
                default: begin
                    if (met) begin
                        if (ph == P_RXW) begin rem = v_in; m_cts = 1'b1; ph = P_RXA; end
                        else if (ph == P_RXA) begin m_cts = 1'b0; ph = P_MRG; end
                        else if (ph == P_TXW) begin m_ctr = 1'b0; ph = P_TXA; end
                        else ph = P_IDLE;
                        waited = 0;
                    end else if (waited >= TO) begin
                        ph = P_ERR; m_err = 1'b1; m_cts = 1'b0; m_ctr = 1'b0;
                    end else begin
                        waited++;
                    end
                end
            endcase
            m_busy = (ph != P_IDLE);
        end
    end

    always @(negedge clock) begin
        chk("cmp_cts",   32'(cts),   32'(m_cts));
        chk("cmp_ctr",   32'(ctr),   32'(m_ctr));
        chk("cmp_v_out", 32'(v_out), 32'(m_vout));
        chk("cmp_pass",  32'(pass),  32'(m_pass));
        chk("cmp_err",   32'(err),   32'(m_err));
        chk("cmp_busy",  32'(busy),  32'(m_busy));
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic press(input int i);
        vote_btn    = '0;
        vote_btn[i] = 1'b1;
        tick();
        vote_btn = '0;
        tick();
    endtask

    task automatic open_round();
        start = 1'b1; tick();
        start = 1'b0; tick();
    endtask

    task automatic close_round();
        start = 1'b1; tick();
        start = 1'b0;
    endtask

    task automatic exchange(input logic [N-1:0] vin);
        rts = 1'b1; v_in = vin; tick();
        chk("cts_raised", 32'(cts), 32'd1);
        tick();
        chk("cts_held", 32'(cts), 32'd1);
        rts = 1'b0; tick();
        chk("cts_dropped", 32'(cts), 32'd0);
        tick();
        chk("ctr_raised", 32'(ctr), 32'd1);
    endtask

    task automatic finish_tx();
        rtr = 1'b1; tick();
        chk("ctr_dropped", 32'(ctr), 32'd0);
        rtr = 1'b0; tick();
        chk("idle_after_tx", 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; key = 1'b0; test = 1'b0;
        vote_btn = '0; rts = 1'b0; v_in = '0; rtr = 1'b0;
        tick(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_v_out", 32'(v_out), 32'd0);
        chk("rst_flags", {28'd0, cts, ctr, pass, err}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Full flow; start edge wins over test in IDLE.
        start = 1'b1; test = 1'b1; tick();
        chk("start_over_test_v_out", 32'(v_out), 32'd0);
        chk("start_over_test_busy", 32'(busy), 32'd1);
        start = 1'b0; test = 1'b0; key = 1'b1; tick();
        press(0); press(1); press(2);
        close_round();
        exchange(4'b0111);
        chk("flow_v_out", 32'(v_out), 32'h7);
        chk("flow_pass", 32'(pass), 32'd1);
        finish_tx();
        chk("flow_hold_v_out", 32'(v_out), 32'h7);

        // Majority boundary; bit3 pressed on the closing start edge still counts.
        open_round();
        press(0); press(1);
        start = 1'b1; vote_btn = 4'b1000; tick();
        start = 1'b0; vote_btn = '0;
        exchange(4'b0111);
        chk("boundary_v_out", 32'(v_out), 32'h3);
        chk("boundary_pass", 32'(pass), 32'd0);
        finish_tx();

        // Key gating and held button.
        open_round();
        key = 1'b0; press(2);
        key = 1'b1; vote_btn = 4'b0010; tick(10);
        vote_btn = '0; tick();
        close_round();
        exchange(4'b1111);
        chk("gate_v_out", 32'(v_out), 32'h2);
        chk("gate_pass", 32'(pass), 32'd0);
        finish_tx();

        // Timeout in RX_WAIT.
        open_round();
        close_round();
        tick(TO);
        chk("to_not_yet", 32'(err), 32'd0);
        tick();
        chk("to_err", 32'(err), 32'd1);
        chk("to_cts", 32'(cts), 32'd0);
        rtr = 1'b1; rts = 1'b1; tick();
        chk("err_ignores", 32'(err), 32'd1);
        rtr = 1'b0; rts = 1'b0; start = 1'b1; tick();
        chk("err_clear", 32'(err), 32'd0);
        chk("err_to_idle", 32'(busy), 32'd0);
        start = 1'b0; tick();

        // Test pattern rotation.
        test = 1'b1; tick();
        chk("test_0", 32'(v_out), 32'h1);
        tick(); chk("test_1", 32'(v_out), 32'h2);
        tick(); chk("test_2", 32'(v_out), 32'h4);
        tick(); chk("test_3", 32'(v_out), 32'h8);
        tick(); chk("test_wrap", 32'(v_out), 32'h1);
        test = 1'b0; tick();
        chk("test_exit_v_out", 32'(v_out), 32'd0);
        chk("test_exit_busy", 32'(busy), 32'd0);

        // Asynchronous reset while waiting for rtr.
        open_round();
        press(0); press(1); press(2);
        close_round();
        exchange(4'b1111);
        chk("pre_rst_v_out", 32'(v_out), 32'h7);
        reset_n = 1'b0;
        #1;
        chk("arst_ctr", 32'(ctr), 32'd0);
        chk("arst_v_out", 32'(v_out), 32'd0);
        chk("arst_pass", 32'(pass), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        start = 1'b1; tick();
        reset_n = 1'b1; tick();
        chk("post_rst_collect", 32'(busy), 32'd1);
        start = 1'b0; tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vote_hub.md
VOTE_HUB -- requirements
Module: vote_hub

Interface
REQ-001 SHALL take parameter N_VOTERS, default 4, range 2..16: number of voters and width of the vote vectors.
REQ-002 SHALL take parameter TIMEOUT, default 15, range 1..255: maximum wait in cycles in any handshake state.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: its rising edge opens and closes collection and clears an error.
REQ-006 SHALL have port key, input, 1 bit: vote-entry enable while collecting.
REQ-007 SHALL have port test, input, 1 bit: test-mode request.
REQ-008 SHALL have port vote_btn, input, N_VOTERS bits: per-voter button; acts on its rising edge.
REQ-009 SHALL have port rts, input, 1 bit: peer request to send remote votes.
REQ-010 SHALL have port v_in, input, N_VOTERS bits: peer vote vector, valid while rts=1.
REQ-011 SHALL have port rtr, input, 1 bit: peer acknowledge of the result.
REQ-012 SHALL have port cts, output, 1 bit: clear-to-send to the peer.
REQ-013 SHALL have port ctr, output, 1 bit: result valid, awaiting rtr.
REQ-014 SHALL have port v_out, output, N_VOTERS bits: result vector or test pattern.
REQ-015 SHALL have port pass, output, 1 bit: majority verdict.
REQ-016 SHALL have port err, output, 1 bit: handshake timeout flag.
REQ-017 SHALL have port busy, output, 1 bit: asserted whenever the state is not IDLE.
REQ-018 SHALL drive every output from a register.

Function
REQ-019 SHALL implement states IDLE, COLLECT, RX_WAIT, RX_ACK, MERGE, TX_WAIT, TX_ACK, TEST and ERROR.
REQ-020 SHALL register start and vote_btn every cycle in every state for edge detection, so a held input acts once.
REQ-021 IDLE: SHALL, on a start rising edge, clear local votes and go to COLLECT; start edge takes priority over test=1.
REQ-022 IDLE: SHALL, with test=1 and no start edge, go to TEST with v_out=1.
REQ-023 TEST: SHALL rotate v_out left by one bit each cycle (bit N_VOTERS-1 wraps to bit 0).
REQ-024 TEST: SHALL, when test=0, clear v_out and go to IDLE.
REQ-025 COLLECT: SHALL set local vote bit i on a vote_btn[i] rising edge while key=1, and SHALL ignore vote_btn edges while key=0.
REQ-026 COLLECT: SHALL leave a set vote bit set until the next COLLECT entry.
REQ-027 COLLECT: SHALL, on a start rising edge, go to RX_WAIT next cycle; a vote edge in that same cycle is counted.
REQ-028 RX_WAIT: SHALL, on an edge with rts=1, capture v_in into remote votes, set cts=1 and go to RX_ACK.
REQ-029 RX_ACK: SHALL hold cts=1 while rts=1, and SHALL, on rts=0, clear cts and go to MERGE.
REQ-030 MERGE: SHALL, in one cycle, load v_out = local AND remote votes and pass = 1 if and only if 2*popcount(v_out) > N_VOTERS, set ctr=1 and go to TX_WAIT.
REQ-031 TX_WAIT: SHALL, on rtr=1, clear ctr and go to TX_ACK.
REQ-032 TX_ACK: SHALL, on rtr=0, go to IDLE.
REQ-033 SHALL hold v_out and pass after TX_ACK until the next MERGE, TEST entry or reset.
REQ-034 SHALL run a timeout counter of width clog2(TIMEOUT+1) that clears on entry to RX_WAIT, RX_ACK, TX_WAIT and TX_ACK and increments each cycle spent in them.
REQ-035 SHALL, when the timeout counter equals TIMEOUT and the awaited condition is absent, go to ERROR with err=1, cts=0 and ctr=0; if the awaited condition occurs in that same cycle it wins.
REQ-036 ERROR: SHALL, on a start rising edge, clear err and go to IDLE; all other inputs are ignored.

Reset
REQ-037 SHALL, while reset_n=0 and independent of clock, force state to IDLE and all of cts, ctr, v_out, pass, err, busy, votes, the counter and the edge registers to 0.
REQ-038 SHALL behave the same for reset asserted mid-handshake; the first edge after release evaluates from IDLE.

Verification
REQ-039 SHALL cover the full flow (N=4): start edge, key=1, btn0..btn2 edges, start edge, rts with v_in=0111 -> cts 1 then 0, v_out=0111, pass=1, ctr=1; rtr 1 then 0 -> IDLE, busy=0.
REQ-040 SHALL cover the majority boundary: local 1011, v_in=0111 -> v_out=0011, pass=0 (2 is not greater than 2).
REQ-041 SHALL cover gating and hold: btn edge with key=0 ignored; btn1 held 10 cycles with key=1 sets only bit1; local 0010, v_in=1111 -> v_out=0010.
REQ-042 SHALL cover timeout: TIMEOUT=15, no rts -> err=1 after 15 cycles in RX_WAIT; start edge -> err=0, IDLE.
REQ-043 SHALL cover test mode: test=1 in IDLE -> v_out 0001, 0010, 0100, 1000, 0001; test=0 -> v_out=0000.
REQ-044 SHALL cover asynchronous reset: reset_n=0 during TX_WAIT with ctr=1 -> ctr, v_out, pass and busy are 0 before the next clock edge.
